limb_carry_normalizer: RTL and testbench
========================================

Name: limb_carry_normalizer

Overview:
- Consumer of the multiplier's product format: 2*NUM_ELEMENTS limbs, each IN_BIT_LEN wide, where limb i has weight 2^(WORD_LEN*i) and its upper bits overlap limb i+1.
- Resolves the carries serially, limb 0 first, and streams canonical WORD_LEN-bit words plus a final carry-out.
- Sits between the squarer/multiplier output register and downstream reduction or host-readback logic.

Parameters:
- NUM_ELEMENTS, 33: input limb count is 2*NUM_ELEMENTS.
- IN_BIT_LEN, 17: input limb width.
- WORD_LEN, 16: output word width.
- LIMBS_PER_CYCLE, 2: limbs resolved per output beat. Must divide 2*NUM_ELEMENTS; elaboration error otherwise.
- CARRY_BIT_LEN, IN_BIT_LEN-WORD_LEN+1: carry register width.
- NUM_BEATS, 2*NUM_ELEMENTS/LIMBS_PER_CYCLE: beats per operand.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand
- in_data  in  [2*NUM_ELEMENTS][IN_BIT_LEN]  redundant limbs, index 0 = LSB
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_word  out  [LIMBS_PER_CYCLE][WORD_LEN]  normalized words; element 0 is the lowest word of the beat
- out_last  out  1  current beat is beat NUM_BEATS-1
- out_carry  out  CARRY_BIT_LEN  final carry-out; meaningful only when out_last=1, otherwise 0

Behaviour:
- Reset is asynchronous on rst_n low. It forces:
  - state IDLE, in_ready=1, out_valid=0, out_last=0;
  - out_word all 0, out_carry=0;
  - carry register 0, beat counter 0.
  - The limb buffer need not be reset.
- State machine has two states, IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture in_data into the limb buffer, compute beat 0 from in_data with carry-in 0, load out_word and the carry register, beat counter <= 1, go to STREAM.
  - out_valid rises the next cycle, so latency from accept to first beat is 1 cycle.
- Per-limb arithmetic, combinational chain within a beat, in limb order:
  - s = limb[WORD_LEN-1:0] + c
  - word = s[WORD_LEN-1:0]
  - c_next = limb[IN_BIT_LEN-1:WORD_LEN] + s[WORD_LEN +: CARRY_BIT_LEN-1]
  - c never exceeds 2^(IN_BIT_LEN-WORD_LEN+1)-2, so it fits CARRY_BIT_LEN without truncation. The verifier asserts this.
- STREAM:
  - in_ready=0, out_valid=1.
  - out_word, out_last and out_carry are registers and stay stable while out_valid&!out_ready.
  - On out_valid&out_ready with a non-last beat: load the next beat from the buffer using the carry register, then increment the beat counter.
  - On out_valid&out_ready with out_last=1: go to IDLE, clear out_valid, out_last and out_carry. No overlap with a new input in that cycle; in_ready rises the following cycle.
- out_last=1 and out_carry = carry-out of limb 2*NUM_ELEMENTS-1 are registered together with the last beat's words.
- Sustained throughput is one beat per cycle with out_ready held high. An operand occupies 1+NUM_BEATS cycles, the extra cycle being the IDLE capture.
- in_data is ignored outside IDLE. in_valid may stay asserted without effect.
- Reset mid-STREAM aborts the operand: no further beats are produced, and in_ready=1 on the first edge after rst_n deasserts.
- Concatenating all out_word values, LSB first, with out_carry on top must equal the integer sum of limb[i]*2^(WORD_LEN*i) exactly.

Test Plan:
- All limbs 0 -> 33 beats, all words 0x0000, out_last only on beat 32, out_carry=0; first out_valid exactly 1 cycle after accept.
- All limbs 0x1FFFF -> word0=0xFFFF, word1=0x0000, words 2..65=0x0001, out_carry=2.
- limb0=0x10000, others 0 -> word0=0x0000, word1=0x0001, rest 0, out_carry=0. Separately, limb65=0x1FFFF, others 0 -> word65=0xFFFF, out_carry=1.
- Random limbs with out_ready toggled pseudo-randomly (~50%) -> outputs held stable while stalled, reconstructed integer matches the reference sum, in_ready=0 throughout STREAM.
- Two operands offered back-to-back with in_valid held high -> second accepted the cycle after the first's last beat handshake; the second's carry chain starts at 0 (no leakage from the first).
- rst_n pulsed low after beat 10 -> out_valid=0 and in_ready=1 immediately (asynchronous); next operand normalizes correctly from beat 0.

Source files
------------

// File: rtl/limb_carry_normalizer.sv
// Serial carry resolver for redundant multiplier limbs: streams canonical WORD_LEN-bit
// words, LIMBS_PER_CYCLE per beat, limb 0 first, plus the final carry-out on the last beat.
module limb_carry_normalizer #(
    parameter int NUM_ELEMENTS    = 33,
    parameter int IN_BIT_LEN      = 17,
    parameter int WORD_LEN        = 16,
    parameter int LIMBS_PER_CYCLE = 2,
    parameter int CARRY_BIT_LEN   = IN_BIT_LEN - WORD_LEN + 1,
    parameter int NUM_BEATS       = 2 * NUM_ELEMENTS / LIMBS_PER_CYCLE
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [2*NUM_ELEMENTS-1:0][IN_BIT_LEN-1:0]     in_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LIMBS_PER_CYCLE-1:0][WORD_LEN-1:0]      out_word,
    output logic                                          out_last,
    output logic [CARRY_BIT_LEN-1:0]                      out_carry
);

    localparam int NUM_LIMBS = 2 * NUM_ELEMENTS;
    localparam int SUM_LEN   = WORD_LEN + CARRY_BIT_LEN - 1;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);
    localparam int IDX_W     = $clog2(NUM_LIMBS + 1);

    if ((NUM_LIMBS % LIMBS_PER_CYCLE) != 0) begin : g_bad_limbs_per_cycle
        $error("LIMBS_PER_CYCLE must divide 2*NUM_ELEMENTS");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                                    state_r;
    logic                                      in_ready_r;
    logic                                      out_valid_r;
    logic                                      out_last_r;
    logic [CARRY_BIT_LEN-1:0]                  out_carry_r;
    logic [LIMBS_PER_CYCLE-1:0][WORD_LEN-1:0]  out_word_r;
    logic [CARRY_BIT_LEN-1:0]                  carry_r;
    logic [CNT_W-1:0]                          beat_cnt_r;
    logic [NUM_LIMBS-1:0][IN_BIT_LEN-1:0]      buf_r;

    logic [CNT_W-1:0]                          beat_sel_s;
    logic [CARRY_BIT_LEN-1:0]                  carry_in_s;
    logic [IDX_W-1:0]                          idx_s;
    logic [LIMBS_PER_CYCLE-1:0][IN_BIT_LEN-1:0] limb_s;
    logic [SUM_LEN-1:0]                        sum_s;
    logic [CARRY_BIT_LEN-1:0]                  chain_c_s;
    logic [LIMBS_PER_CYCLE-1:0][WORD_LEN-1:0]  word_s;
    logic                                      load_last_s;
    logic                                      accept_s;

    assign accept_s = (state_r == ST_IDLE) && in_valid && in_ready_r;

    // Select the beat's source limbs and run the per-limb carry chain.
    // The IDLE beat always starts from carry 0 so a previous operand cannot leak in.
    always_comb begin
        beat_sel_s = '0;
        carry_in_s = '0;
        idx_s      = '0;
        limb_s     = '0;
        sum_s      = '0;
        chain_c_s  = '0;
        word_s     = '0;
        if (state_r == ST_IDLE) begin
            beat_sel_s = '0;
            carry_in_s = '0;
        end else if (beat_cnt_r < CNT_W'(NUM_BEATS)) begin
            beat_sel_s = beat_cnt_r;
            carry_in_s = carry_r;
        end else begin
            beat_sel_s = '0;
            carry_in_s = '0;
        end
        for (int j = 0; j < LIMBS_PER_CYCLE; j++) begin
            idx_s = IDX_W'(beat_sel_s) * IDX_W'(LIMBS_PER_CYCLE) + IDX_W'(j);
            if (state_r == ST_IDLE) begin
                limb_s[j] = in_data[idx_s];
            end else begin
                limb_s[j] = buf_r[idx_s];
            end
        end
        chain_c_s = carry_in_s;
        for (int j = 0; j < LIMBS_PER_CYCLE; j++) begin
            sum_s     = SUM_LEN'(limb_s[j][WORD_LEN-1:0]) + SUM_LEN'(chain_c_s);
            word_s[j] = sum_s[WORD_LEN-1:0];
            chain_c_s = CARRY_BIT_LEN'(limb_s[j][IN_BIT_LEN-1:WORD_LEN])
                      + CARRY_BIT_LEN'(sum_s[SUM_LEN-1:WORD_LEN]);
        end
    end

    assign load_last_s = (beat_sel_s == CNT_W'(NUM_BEATS - 1));

    // Operand buffer; only its captured contents are ever read, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_r <= in_data;
        end
    end

    // Control FSM with registered handshake and output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_carry_r <= '0;
            out_word_r  <= '0;
            carry_r     <= '0;
            beat_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r     <= ST_STREAM;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_word_r  <= word_s;
                        carry_r     <= chain_c_s;
                        out_last_r  <= load_last_s;
                        out_carry_r <= load_last_s ? chain_c_s : '0;
                        beat_cnt_r  <= CNT_W'(1);
                    end else begin
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (out_ready && out_last_r) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        out_carry_r <= '0;
                        carry_r     <= '0;
                        beat_cnt_r  <= '0;
                    end else if (out_ready) begin
                        out_word_r  <= word_s;
                        carry_r     <= chain_c_s;
                        out_last_r  <= load_last_s;
                        out_carry_r <= load_last_s ? chain_c_s : '0;
                        beat_cnt_r  <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_carry_r <= '0;
                    carry_r     <= '0;
                    beat_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_last  = out_last_r;
    assign out_carry = out_carry_r;

endmodule

// File: tb/tb_limb_carry_normalizer.sv
// Scoreboard bench for limb_carry_normalizer: expected beats are queued at stimulus time
// (constants or a big-integer sum) and popped as the DUT hands beats off.
module tb_limb_carry_normalizer;

    localparam int NE  = 33;
    localparam int IBL = 17;
    localparam int WL  = 16;
    localparam int LPC = 2;
    localparam int CBL = 2;
    localparam int NB  = 33;
    localparam int NL  = 66;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [NL-1:0][IBL-1:0]   in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [LPC-1:0][WL-1:0]   out_word;
    logic                     out_last;
    logic [CBL-1:0]           out_carry;

    typedef struct packed {
        logic [31:0] words;
        logic        last;
        logic [1:0]  carry;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    limb_carry_normalizer #(
        .NUM_ELEMENTS(NE), .IN_BIT_LEN(IBL), .WORD_LEN(WL), .LIMBS_PER_CYCLE(LPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .out_carry(out_carry)
    );

    // Reference: the exact integer sum of limb[i]*2^(16*i), sliced into beats.
    task automatic push_model(input logic [NL-1:0][IBL-1:0] limbs);
        logic [1087:0] total;
        exp_t e;
        total = '0;
        for (int i = 0; i < NL; i++) total = total + ({1071'b0, limbs[i]} << (WL * i));
        for (int b = 0; b < NB; b++) begin
            e.words = total[32*b +: 32];
            e.last  = (b == NB - 1);
            e.carry = (b == NB - 1) ? total[1056 +: 2] : 2'b00;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_const(input logic [31:0] first, input logic [31:0] mid,
                              input logic [31:0] last_w, input logic [1:0] carry);
        exp_t e;
        for (int b = 0; b < NB; b++) begin
            e.words = (b == 0) ? first : ((b == NB - 1) ? last_w : mid);
            e.last  = (b == NB - 1);
            e.carry = (b == NB - 1) ? carry : 2'b00;
            sb_q.push_back(e);
        end
    endtask

    task automatic gen_random(output logic [NL-1:0][IBL-1:0] v);
        for (int i = 0; i < NL; i++) v[i] = IBL'($urandom);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting posedge.
    task automatic offer(input logic [NL-1:0][IBL-1:0] limbs, input bit hold);
        int guard;
        guard = 0;
        in_data  = limbs;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++; failures++;
            $display("FAIL offer_timeout: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Consume up to max_beats beats, comparing each valid beat to the queue head every cycle.
    task automatic drain(input bit stall_en, input int max_beats, input string tag);
        int   guard;
        int   beats;
        exp_t e;
        bit   rdy;
        guard = 0;
        beats = 0;
        while (sb_q.size() > 0 && beats < max_beats && guard < 4000) begin
            rdy = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = rdy;
            if (stall_en) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data[$urandom_range(0, NL - 1)] = IBL'($urandom);
            end
            if (out_valid === 1'b1) begin
                e = sb_q[0];
                checks++;
                if ({out_word, out_last, out_carry} !== {e.words, e.last, e.carry}) begin
                    failures++;
                    $display("FAIL %s beat%0d: got word=%h last=%b carry=%0d, required word=%h last=%b carry=%0d",
                             tag, NB - sb_q.size(), out_word, out_last, out_carry, e.words, e.last, e.carry);
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s in_ready_stream: got %b, required 0", tag, in_ready);
                end
                if (rdy) begin
                    void'(sb_q.pop_front());
                    beats++;
                end
            end
            @(negedge clk);
            guard++;
        end
        if (stall_en) in_valid = 1'b0;
        out_ready = 1'b1;
        if (guard >= 4000) begin
            checks++; failures++;
            $display("FAIL %s drain_timeout: %0d beats left, required 0", tag, sb_q.size());
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_carry !== 2'b00) begin
            failures++;
            $display("FAIL %s idle: got valid=%b ready=%b last=%b carry=%0d, required 0 1 0 0",
                     tag, out_valid, in_ready, out_last, out_carry);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        checks++;
        if (out_word !== 32'h0) begin
            failures++;
            $display("FAIL reset_word: got %h, required 00000000", out_word);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_zero();
        logic [NL-1:0][IBL-1:0] v;
        v = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_pre_valid: got %b, required 0", out_valid);
        end
        push_const(32'h0, 32'h0, 32'h0, 2'd0);
        offer(v, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_latency: out_valid=%b one cycle after accept, required 1", out_valid);
        end
        drain(1'b0, NB, "zero");
        check_idle("zero_end");
    endtask

    task automatic test_ones();
        logic [NL-1:0][IBL-1:0] v;
        for (int i = 0; i < NL; i++) v[i] = 17'h1FFFF;
        push_const(32'h0000FFFF, 32'h00010001, 32'h00010001, 2'd2);
        offer(v, 1'b0);
        drain(1'b0, NB, "ones");
        check_idle("ones_end");
    endtask

    task automatic test_single_limbs();
        logic [NL-1:0][IBL-1:0] v;
        v = '0;
        v[0] = 17'h10000;
        push_const(32'h00010000, 32'h0, 32'h0, 2'd0);
        offer(v, 1'b0);
        drain(1'b0, NB, "limb0");
        v = '0;
        v[NL-1] = 17'h1FFFF;
        push_const(32'h0, 32'h0, 32'hFFFF0000, 2'd1);
        offer(v, 1'b0);
        drain(1'b0, NB, "limb65");
        check_idle("limb65_end");
    endtask

    task automatic test_random_stall();
        logic [NL-1:0][IBL-1:0] v;
        for (int k = 0; k < 3; k++) begin
            gen_random(v);
            push_model(v);
            offer(v, 1'b0);
            drain(1'b1, NB, "rand_stall");
        end
        check_idle("rand_end");
    endtask

    task automatic test_back_to_back();
        logic [NL-1:0][IBL-1:0] a;
        logic [NL-1:0][IBL-1:0] b;
        for (int i = 0; i < NL; i++) a[i] = 17'h1FFFF;
        b = '0;
        b[0] = 17'h10000;
        push_model(a);
        offer(a, 1'b1);
        in_data = b;
        drain(1'b0, NB, "b2b_first");
        check_idle("b2b_gap");
        push_model(b);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_accept: out_valid=%b, required 1", out_valid);
        end
        drain(1'b0, NB, "b2b_second");
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid_stream();
        logic [NL-1:0][IBL-1:0] v;
        gen_random(v);
        push_model(v);
        offer(v, 1'b0);
        drain(1'b0, 10, "abort_pre");
        rst_n = 1'b0;
        #1;
        check_idle("abort_async");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_release");
        gen_random(v);
        push_model(v);
        offer(v, 1'b0);
        drain(1'b0, NB, "abort_next");
        check_idle("abort_end");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_single_limbs();
        test_random_stall();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
